// File: rtl/data_sram_pkg.sv
// Shared types and constants for the byte-lane data memory.
package data_sram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_t;

    localparam int unsigned CNT_W = 4;

    localparam logic CHIP_EN   = 1'b1;
    localparam logic CHIP_DIS  = 1'b0;
    localparam logic WRITE_EN  = 1'b1;
    localparam logic WRITE_DIS = 1'b0;

endpackage

// File: rtl/sram_byte_bank.sv
// One 8-bit wide synchronous RAM lane; read-first, output held while disabled.
module sram_byte_bank #(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [7:0]            din,
    output logic [7:0]            dout
);

    logic [7:0] mem [0:(1 << DEPTH_LOG2) - 1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= din;
            end
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/data_sram.sv
// Byte-lane data memory with valid/ready handshake, wait states,
// masked reads and out-of-range error responses.
module data_sram
    import data_sram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [DATA_WIDTH/8-1:0]   req_sel,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [DATA_WIDTH-1:0]     resp_rdata,
    output logic                      resp_err
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned OFF   = $clog2(BYTES);
    localparam int unsigned HI    = DEPTH_LOG2 + OFF;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic                    cap_we;
    logic                    cap_err;
    logic [BYTES-1:0]        cap_sel;
    logic [DEPTH_LOG2-1:0]   cap_idx;
    logic [DATA_WIDTH-1:0]   cap_wdata;
    logic [DATA_WIDTH-1:0]   bank_dout;
    logic [DATA_WIDTH-1:0]   masked;
    logic                    req_err;
    logic                    bank_en;
    logic                    unused_addr_bits;

    assign req_err          = |(req_addr >> HI);
    assign unused_addr_bits = ^req_addr;

    // Gating with rst keeps a write aborted on the access edge from landing.
    assign bank_en = (state == ACCESS) && !rst && !cap_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_err   <= 1'b0;
            cap_sel   <= '0;
            cap_idx   <= '0;
            cap_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_we    <= req_we;
                        cap_err   <= req_err;
                        cap_sel   <= req_sel;
                        cap_idx   <= req_addr[HI-1:OFF];
                        cap_wdata <= req_wdata;
                        if (WAIT_CYCLES > 0) begin
                            state <= WAIT;
                            cnt   <= CNT_W'(WAIT_CYCLES - 1);
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= ACCESS;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACCESS: state <= RESP;
                RESP: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < BYTES; i++) begin : g_lane
        sram_byte_bank #(
            .DEPTH_LOG2(DEPTH_LOG2)
        ) u_bank (
            .clk  (clk),
            .en   (bank_en ? CHIP_EN : CHIP_DIS),
            .we   ((cap_we && cap_sel[i]) ? WRITE_EN : WRITE_DIS),
            .addr (cap_idx),
            .din  (cap_wdata[8*i +: 8]),
            .dout (bank_dout[8*i +: 8])
        );
        assign masked[8*i +: 8] = cap_sel[i] ? bank_dout[8*i +: 8] : 8'h00;
    end

    // Bank output only changes on the access edge, so it is stable through RESP.
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_err   = resp_valid && cap_err;
    assign resp_rdata = (resp_valid && !cap_we && !cap_err) ? masked : '0;

endmodule

// File: doc/data_sram.md
# data_sram

Parametrised, byte-lane data memory with a valid/ready request/response handshake, configurable wait states, masked reads and out-of-range error reporting. It replaces the fixed 32-bit, combinational-read data RAM behind the MEM stage. It services one outstanding access at a time and lets the pipeline stall on `req_ready`/`resp_valid`.

## Interface
- `DATA_WIDTH`, 32: word width in bits; multiple of 8; `BYTES = DATA_WIDTH/8`.
- `ADDR_WIDTH`, 32: byte-address width.
- `DEPTH_LOG2`, 10: log2 of the number of words.
- `WAIT_CYCLES`, 0: extra cycles inserted before each access, 0..15.

Ports:
- `clk` in 1: the single clock; all logic updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in 1: a request is present.
- `req_ready` out 1: the block can accept a request.
- `req_we` in 1: 1 = write, 0 = read.
- `req_sel` in `BYTES`: byte-lane enables; bit i covers `data[8i+7:8i]`.
- `req_addr` in `ADDR_WIDTH`: byte address; low log2(`BYTES`) bits are ignored.
- `req_wdata` in `DATA_WIDTH`: write data.
- `resp_valid` out 1: a response is present.
- `resp_ready` in 1: the consumer takes the response.
- `resp_rdata` out `DATA_WIDTH`: read data (masked).
- `resp_err` out 1: the access was out of range.

## Operation
- **Word index:** `req_addr[DEPTH_LOG2+OFF-1:OFF]`, where `OFF = log2(BYTES)`.
- **Out of range:** any nonzero bit in `req_addr[ADDR_WIDTH-1:DEPTH_LOG2+OFF]`. The access sets `resp_err=1` and `resp_rdata=0`, and memory is not touched.
- **FSM states:** IDLE, WAIT, ACCESS, RESP.
- **IDLE:** `req_ready=1`. When `req_valid` is high, capture we/sel/addr/wdata. Go to WAIT if `WAIT_CYCLES>0` (counter loaded with `WAIT_CYCLES-1`), else go to ACCESS.
- **WAIT:** decrement the counter. At 0, go to ACCESS.
- **ACCESS:** perform the access on the edge.
  - Write: update only the lanes where sel=1. `resp_rdata=0`.
  - Read: register the word with lanes where sel=0 forced to 0x00.
  - Go to RESP with `resp_valid=1`.
- **RESP:** `resp_valid`, `resp_rdata` and `resp_err` are held stable until `resp_valid && resp_ready`, then return to IDLE.
- **Ready in other states:** `req_ready=0` in WAIT, ACCESS and RESP. Requests there are ignored; the requester must hold them.
- **sel=0 write:** legal no-op; the block still responds with `resp_err=0`.
- **Reset:** rst has priority in every state. It returns to IDLE, clears the counter and drops any captured request, including an aborted write, which leaves memory unchanged. Memory contents are not reset.
- **Reset values:** `req_ready=1`, `resp_valid=0`, `resp_rdata=0`, `resp_err=0`.

## Timing
- Accept edge E0 (IDLE, `req_valid`). The access happens at edge E0+1+`WAIT_CYCLES`. `resp_valid` rises after that edge.
- Latency from accept to `resp_valid` is `WAIT_CYCLES+1` cycles.
- Back-to-back rate is one access per `WAIT_CYCLES+3` cycles when `resp_ready` is held at 1: accept, [wait], access, response, then the next accept.
- The read is synchronous; there is no combinational path from `req_*` to `resp_*`.
- `req_ready` and `resp_valid` are decoded directly from the state register.

## Structure
- **Shared package `data_sram_pkg`:** state enum (IDLE, WAIT, ACCESS, RESP), wait-counter width (4), `CHIP_*`/`WRITE_*` style enable constants.
- **Sub-module `sram_byte_bank`:** one 8-bit × 2^`DEPTH_LOG2` synchronous RAM with we/addr/din/dout, instantiated `BYTES` times by generate. This keeps each lane inferable as block RAM.
- **Top level:** FSM, request capture register, wait counter, range check, read masking.

## Test plan
- **Full write/read:** `DATA_WIDTH=32`, W=0. Write 0xDEADBEEF, sel=4'b1111, addr 0x10, then read addr 0x10 with sel=1111 → `resp_rdata=0xDEADBEEF`, `resp_err=0`, and `resp_valid` is 1 cycle after each accept.
- **Partial write:** write 0x0000AA00 with sel=0010 to 0x10, then read with sel=1111 → 0xDEADAAEF. A read with sel=0001 → 0x000000EF.
- **Out of range:** `DEPTH_LOG2=10`. Write to 0x1000 → `resp_err=1`, `resp_rdata=0`. Read 0x000 still returns its previous value.
- **Backpressure:** hold `resp_ready=0` for 5 cycles after `resp_valid` while `req_valid` stays 1 → response stable, `req_ready=0` throughout. Raising `resp_ready` → IDLE; the next request is accepted on the following edge.
- **Wait states:** `WAIT_CYCLES=3`, read accepted at E0 → `resp_valid` rises after edge E0+4. Repeated reads with `resp_ready=1` are accepted every 6 cycles.
- **Reset mid-operation:** `WAIT_CYCLES=3`, write 0x12345678 to 0x20, assert rst at E0+2 → IDLE, `resp_valid=0`, no response. A following read of 0x20 returns the old contents.
